// File: rtl/fetch_stage.sv
// Purpose : MIPS instruction-fetch stage. It holds the word-addressed fetch PC, issues requests over
//           req/gnt/rvalid, and buffers returned words in a 2-entry FIFO that feeds decode.
// Latency : a grant in cycle n with rvalid in n+1 makes the entry visible in n+2.
//           Peak throughput is one instruction per 2 cycles.
// Backpr. : decode stalls via i_ready. Requests stop once FIFO entries plus the outstanding request reach 2.
//
// Ports:
//   i_clk, i_rst                        clock and asynchronous active-high reset
//   i_redirect, i_target                taken branch/jump and its word-address target
//   o_imem_req, o_imem_addr             fetch request and its word address
//   i_imem_gnt                          memory accepted the request this cycle
//   i_imem_rvalid, i_imem_rdata         returned instruction word
//   o_valid, i_ready                    decode handshake
//   o_instr, o_pc, o_pc_next            head entry and its sequential successor (branch base)

module fetch_stage #(
    parameter logic [29:0] RESET_PC = 30'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_redirect,
    input  logic [29:0] i_target,
    output logic        o_imem_req,
    output logic [29:0] o_imem_addr,
    input  logic        i_imem_gnt,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_instr,
    output logic [29:0] o_pc,
    output logic [29:0] o_pc_next
);

    typedef enum logic {
        ST_ISSUE = 1'b0,
        ST_WAIT  = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [29:0] r_fpc;
    logic [29:0] r_inflight;
    logic        r_discard;

    logic [29:0] r_fifo_pc    [2];
    logic [31:0] r_fifo_instr [2];
    logic        r_rd_ptr;
    logic        r_wr_ptr;
    logic [1:0]  r_count;

    logic        w_in_wait;
    logic [1:0]  w_occupancy;
    logic        w_credit;
    logic        w_grant;
    logic        w_resp;
    logic        w_push;
    logic        w_pop;
    logic        w_head_vld;

    // ------------------------------------------------------------------
    // Credit and handshake qualification
    // ------------------------------------------------------------------
    assign w_in_wait   = (r_state == ST_WAIT);
    // An outstanding request already owns a FIFO slot. The sum therefore
    // never exceeds 3, so it fits in 2 bits.
    assign w_occupancy = r_count + {1'b0, w_in_wait};
    assign w_credit    = (w_occupancy < 2'd2);

    // The request is masked during a redirect. A grant that still arrives in
    // that cycle was issued against the address shown last cycle, so it is
    // accepted and its response is later discarded.
    assign w_grant     = !w_in_wait && w_credit && i_imem_gnt;
    assign w_resp      = w_in_wait && i_imem_rvalid;
    assign w_push      = w_resp && !r_discard && !i_redirect;
    // A redirect flushes the FIFO, so a pop in the same cycle has no effect.
    assign w_pop       = (r_count != 2'd0) && i_ready && !i_redirect;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_ISSUE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_ISSUE: begin
                if (w_grant) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (i_imem_rvalid) begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            default: w_state_nxt = ST_ISSUE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        o_imem_req  = 1'b0;
        o_imem_addr = r_fpc;
        case (r_state)
            ST_ISSUE: o_imem_req = w_credit && !i_redirect && !i_rst;
            ST_WAIT:  o_imem_req = 1'b0;
            default:  o_imem_req = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Fetch PC and in-flight request PC
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_fpc      <= RESET_PC;
            r_inflight <= 30'd0;
        end else begin
            if (i_redirect) begin
                // The target is the next address to fetch, even when the
                // old address is granted in this same cycle.
                r_fpc <= i_target;
            end else if (w_grant) begin
                r_fpc <= r_fpc + 30'd1;
            end
            if (w_grant) begin
                r_inflight <= r_fpc;
            end
        end
    end

    // ------------------------------------------------------------------
    // Discard flag: marks the outstanding response as wrong-path
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_discard <= 1'b0;
        end else if (i_redirect) begin
            if (w_resp) begin
                // The response arriving now is dropped directly, so nothing
                // remains to be discarded.
                r_discard <= 1'b0;
            end else if (w_in_wait || w_grant) begin
                r_discard <= 1'b1;
            end
        end else if (w_resp) begin
            r_discard <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // 2-entry {pc, instr} FIFO
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < 2; i++) begin
                r_fifo_pc[i]    <= 30'd0;
                r_fifo_instr[i] <= 32'd0;
            end
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (i_redirect) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            // Credit keeps a push from ever landing on a full FIFO.
            if (w_push) begin
                r_fifo_pc[r_wr_ptr]    <= r_inflight;
                r_fifo_instr[r_wr_ptr] <= i_imem_rdata;
                r_wr_ptr               <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Decode-side outputs. They are forced to zero when the FIFO is empty.
    // ------------------------------------------------------------------
    assign w_head_vld = (r_count != 2'd0);
    assign o_valid    = w_head_vld;
    assign o_instr    = w_head_vld ? r_fifo_instr[r_rd_ptr] : 32'd0;
    assign o_pc       = w_head_vld ? r_fifo_pc[r_rd_ptr] : 30'd0;
    assign o_pc_next  = w_head_vld ? (r_fifo_pc[r_rd_ptr] + 30'd1) : 30'd0;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    logic        clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Main DUT (RESET_PC = 0x100)
    logic        i_rst;
    logic        i_redirect;
    logic [29:0] i_target;
    logic        o_imem_req;
    logic [29:0] o_imem_addr;
    logic        i_imem_gnt;
    logic        i_imem_rvalid;
    logic [31:0] i_imem_rdata;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_instr;
    logic [29:0] o_pc;
    logic [29:0] o_pc_next;

    // Wrap DUT (RESET_PC = 0x3FFFFFFF)
    logic        b_redirect;
    logic [29:0] b_target;
    logic        b_req;
    logic [29:0] b_addr;
    logic        b_gnt;
    logic        b_rvalid;
    logic [31:0] b_rdata;
    logic        b_valid;
    logic        b_ready;
    logic [31:0] b_instr;
    logic [29:0] b_pc;
    logic [29:0] b_pc_next;

    fetch_stage #(.RESET_PC(30'h100)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_redirect(i_redirect), .i_target(i_target),
        .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr), .i_imem_gnt(i_imem_gnt),
        .i_imem_rvalid(i_imem_rvalid), .i_imem_rdata(i_imem_rdata), .o_valid(o_valid),
        .i_ready(i_ready), .o_instr(o_instr), .o_pc(o_pc), .o_pc_next(o_pc_next)
    );

    fetch_stage #(.RESET_PC(30'h3FFF_FFFF)) dut_wrap (
        .i_clk(clk), .i_rst(i_rst), .i_redirect(b_redirect), .i_target(b_target),
        .o_imem_req(b_req), .o_imem_addr(b_addr), .i_imem_gnt(b_gnt),
        .i_imem_rvalid(b_rvalid), .i_imem_rdata(b_rdata), .o_valid(b_valid),
        .i_ready(b_ready), .o_instr(b_instr), .o_pc(b_pc), .o_pc_next(b_pc_next)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [29:0] exp_q [$];

    // Values applied at the start of the next cycle (posedge + 1).
    // Redirect, gnt and rvalid are one-shot.
    logic        nx_rst, nx_redirect, nx_ready, nx_gnt, nx_rvalid;
    logic [29:0] nx_target;
    logic [31:0] nx_rdata;
    logic        nx2_gnt, nx2_rvalid;
    logic [31:0] nx2_rdata;

    // Auto memory: grants every request, returns data mem_lat cycles later
    logic        mem_auto;
    int          mem_lat;
    logic        mem_pend;
    int          mem_cnt;
    logic [29:0] mem_addr;

    function automatic logic [31:0] instr_of(input logic [29:0] pc);
        return {2'b10, pc} ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance one cycle. Inputs change at posedge+1; the call returns at negedge+1.
    task automatic cycle();
        @(posedge clk);
        #1;
        i_rst      = nx_rst;
        i_redirect = nx_redirect;
        i_target   = nx_target;
        i_ready    = nx_ready;
        nx_redirect = 1'b0;
        b_gnt    = nx2_gnt;
        b_rvalid = nx2_rvalid;
        b_rdata  = nx2_rdata;
        nx2_gnt    = 1'b0;
        nx2_rvalid = 1'b0;
        #1;
        if (mem_auto) begin
            i_imem_gnt    = 1'b0;
            i_imem_rvalid = 1'b0;
            if (mem_pend) begin
                if (mem_cnt == 0) begin
                    i_imem_rvalid = 1'b1;
                    i_imem_rdata  = instr_of(mem_addr);
                    mem_pend      = 1'b0;
                end else begin
                    mem_cnt--;
                end
            end
            if (o_imem_req) begin
                i_imem_gnt = 1'b1;
                mem_pend   = 1'b1;
                mem_cnt    = mem_lat - 1;
                mem_addr   = o_imem_addr;
            end
        end else begin
            i_imem_gnt    = nx_gnt;
            i_imem_rvalid = nx_rvalid;
            i_imem_rdata  = nx_rdata;
            nx_gnt    = 1'b0;
            nx_rvalid = 1'b0;
        end
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        nx_rst   = 1'b1;
        mem_auto = 1'b0;
        mem_pend = 1'b0;
        cycle();
        cycle();
    endtask

    // Run until every expected entry has been seen, then stall decode.
    task automatic drain(input string name);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 40) begin
            cycle();
            k++;
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL %s_drain: %0d entries outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
        nx_ready = 1'b0;
    endtask

    // Monitor: compares every accepted decode entry against the scoreboard
    initial begin
        forever begin
            @(negedge clk);
            if (!i_rst && o_valid && i_ready && !i_redirect) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL sb_unexpected: got pc %h, expected no entry", o_pc);
                end else begin
                    logic [29:0] e;
                    logic [29:0] en;
                    e  = exp_q.pop_front();
                    en = e + 30'd1;
                    chk("sb_pc", 32'(o_pc), 32'(e));
                    chk("sb_instr", o_instr, instr_of(e));
                    chk("sb_pc_next", 32'(o_pc_next), 32'(en));
                end
            end
        end
    end

    initial begin
        i_rst = 1'b1; i_redirect = 1'b0; i_target = '0; i_ready = 1'b0;
        i_imem_gnt = 1'b0; i_imem_rvalid = 1'b0; i_imem_rdata = '0;
        b_redirect = 1'b0; b_target = '0; b_gnt = 1'b0; b_rvalid = 1'b0;
        b_rdata = '0; b_ready = 1'b0;
        nx_rst = 1'b1; nx_redirect = 1'b0; nx_ready = 1'b0; nx_gnt = 1'b0;
        nx_rvalid = 1'b0; nx_target = '0; nx_rdata = '0;
        nx2_gnt = 1'b0; nx2_rvalid = 1'b0; nx2_rdata = '0;
        mem_auto = 1'b0; mem_lat = 1; mem_pend = 1'b0; mem_cnt = 0; mem_addr = '0;

        // Reset state
        cycle();
        cycle();
        chk("rst_req", 32'(o_imem_req), 32'd0);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_instr", o_instr, 32'd0);
        chk("rst_pc", 32'(o_pc), 32'd0);
        chk("rst_pc_next", 32'(o_pc_next), 32'd0);
        chk("rst_wrap_req", 32'(b_req), 32'd0);

        // Sequential fetch, 1-cycle memory
        nx_ready = 1'b1; mem_auto = 1'b1; mem_lat = 1;
        exp_q.push_back(30'h100); exp_q.push_back(30'h101); exp_q.push_back(30'h102);
        nx_rst = 1'b0;
        cycle();
        chk("seq_c0_req", 32'(o_imem_req), 32'd1);
        chk("seq_c0_addr", 32'(o_imem_addr), 32'h100);
        chk("seq_c0_valid", 32'(o_valid), 32'd0);
        cycle();
        chk("seq_c1_req", 32'(o_imem_req), 32'd0);
        chk("seq_c1_valid", 32'(o_valid), 32'd0);
        cycle();
        chk("seq_c2_valid", 32'(o_valid), 32'd1);
        chk("seq_c2_req", 32'(o_imem_req), 32'd1);
        chk("seq_c2_addr", 32'(o_imem_addr), 32'h101);
        drain("seq");

        // Backpressure: two entries accumulate, then requests stop
        do_reset();
        nx_ready = 1'b0; mem_auto = 1'b1; mem_lat = 1; nx_rst = 1'b0;
        repeat (10) cycle();
        chk("bp_req_stalled", 32'(o_imem_req), 32'd0);
        chk("bp_valid", 32'(o_valid), 32'd1);
        chk("bp_head_pc", 32'(o_pc), 32'h100);
        exp_q.push_back(30'h100); exp_q.push_back(30'h101); exp_q.push_back(30'h102);
        nx_ready = 1'b1;
        cycle();
        chk("bp_release_req", 32'(o_imem_req), 32'd0);
        cycle();
        chk("bp_resume_req", 32'(o_imem_req), 32'd1);
        chk("bp_resume_addr", 32'(o_imem_addr), 32'h102);
        drain("bp");

        // Redirect while waiting for rdata (3-cycle memory)
        do_reset();
        nx_ready = 1'b1; mem_auto = 1'b1; mem_lat = 3; nx_rst = 1'b0;
        cycle();
        nx_redirect = 1'b1; nx_target = 30'h2000;
        cycle();
        exp_q.push_back(30'h2000);
        cycle();
        chk("rdw_valid", 32'(o_valid), 32'd0);
        chk("rdw_req_wait", 32'(o_imem_req), 32'd0);
        cycle();
        chk("rdw_late_rsp_req", 32'(o_imem_req), 32'd0);
        cycle();
        chk("rdw_req", 32'(o_imem_req), 32'd1);
        chk("rdw_addr", 32'(o_imem_addr), 32'h2000);
        drain("rdw");

        // Redirect flushes a full FIFO, and the same-cycle pop is void
        do_reset();
        nx_ready = 1'b0; mem_auto = 1'b1; mem_lat = 1; nx_rst = 1'b0;
        repeat (5) cycle();
        chk("fl_full_valid", 32'(o_valid), 32'd1);
        nx_redirect = 1'b1; nx_target = 30'h300; nx_ready = 1'b1;
        cycle();
        exp_q.push_back(30'h300);
        cycle();
        chk("fl_valid", 32'(o_valid), 32'd0);
        chk("fl_req", 32'(o_imem_req), 32'd1);
        chk("fl_addr", 32'(o_imem_addr), 32'h300);
        drain("fl");

        // Redirect coincident with grant of 0x105
        do_reset();
        nx_ready = 1'b1; mem_auto = 1'b0; nx_rst = 1'b0;
        nx_redirect = 1'b1; nx_target = 30'h105;
        cycle();
        chk("rg_c0_req", 32'(o_imem_req), 32'd0);
        nx_redirect = 1'b1; nx_target = 30'h40; nx_gnt = 1'b1;
        cycle();
        chk("rg_c1_addr", 32'(o_imem_addr), 32'h105);
        nx_rvalid = 1'b1; nx_rdata = instr_of(30'h105);
        cycle();
        chk("rg_c2_req", 32'(o_imem_req), 32'd0);
        chk("rg_c2_valid", 32'(o_valid), 32'd0);
        exp_q.push_back(30'h40);
        mem_auto = 1'b1; mem_lat = 1; mem_pend = 1'b0;
        cycle();
        chk("rg_req", 32'(o_imem_req), 32'd1);
        chk("rg_addr", 32'(o_imem_addr), 32'h40);
        drain("rg");

        // Asynchronous reset mid-WAIT with one entry buffered
        do_reset();
        nx_ready = 1'b0; mem_auto = 1'b1; mem_lat = 3; nx_rst = 1'b0;
        repeat (6) cycle();
        chk("ar_pre_valid", 32'(o_valid), 32'd1);
        chk("ar_pre_req", 32'(o_imem_req), 32'd0);
        i_rst = 1'b1; nx_rst = 1'b1; mem_auto = 1'b0; mem_pend = 1'b0;
        #1;
        chk("ar_valid", 32'(o_valid), 32'd0);
        chk("ar_req", 32'(o_imem_req), 32'd0);
        chk("ar_pc", 32'(o_pc), 32'd0);
        cycle();
        nx_rst = 1'b0; nx_rvalid = 1'b1; nx_rdata = 32'hDEAD_BEEF;
        cycle();
        chk("ar_c0_req", 32'(o_imem_req), 32'd1);
        chk("ar_c0_addr", 32'(o_imem_addr), 32'h100);
        cycle();
        chk("ar_stray_valid", 32'(o_valid), 32'd0);
        chk("ar_c1_req", 32'(o_imem_req), 32'd1);
        chk("ar_c1_addr", 32'(o_imem_addr), 32'h100);

        // 30-bit wrap of the fetch PC and of o_pc_next
        do_reset();
        nx_rst = 1'b0; nx2_gnt = 1'b1;
        cycle();
        chk("wr_c0_req", 32'(b_req), 32'd1);
        chk("wr_c0_addr", 32'(b_addr), 32'h3FFF_FFFF);
        nx2_rvalid = 1'b1; nx2_rdata = 32'h1234_5678;
        cycle();
        chk("wr_c1_req", 32'(b_req), 32'd0);
        cycle();
        chk("wr_valid", 32'(b_valid), 32'd1);
        chk("wr_pc", 32'(b_pc), 32'h3FFF_FFFF);
        chk("wr_pc_next", 32'(b_pc_next), 32'd0);
        chk("wr_instr", b_instr, 32'h1234_5678);
        chk("wr_req2", 32'(b_req), 32'd1);
        chk("wr_addr2", 32'(b_addr), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
